inst_feeder: RTL and testbench

Synthesizable instruction-issue controller that drives the single-cycle processor's `in_valid`/`inst` handshake from an on-chip instruction memory and follows the processor's `out_valid`/`inst_addr` response as the next fetch address. It is the on-chip counterpart of the processor's instruction port. It sits between a host load port and the processor, and counts retired instructions. It flags latency timeouts, handshake violations and out-of-range fetch addresses.

---
 rtl/inst_feeder_pkg.sv | 22 ++
 rtl/inst_feeder_imem.sv | 25 ++
 rtl/inst_feeder.sv | 137 +++++++++++++
 tb/tb_inst_feeder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_feeder_pkg.sv
// Shared constants for the instruction feeder: FSM encodings, fault codes
// and the fetch-address legality check.
package inst_feeder_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam logic [1:0] FLT_NONE    = 2'd0;
  localparam logic [1:0] FLT_TIMEOUT = 2'd1;
  localparam logic [1:0] FLT_PROTO   = 2'd2;
  localparam logic [1:0] FLT_ADDR    = 2'd3;

  // A fetch address must be word aligned and inside the instruction memory.
  function automatic logic fetch_addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr < (32'(depth) * 32'd4));
  endfunction

endpackage

// File: rtl/inst_feeder_imem.sv
// Instruction memory: one write port, one synchronous read port with a
// single cycle of read latency. Contents survive reset.
module inst_feeder_imem #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_feeder.sv
// Issue controller: feeds instructions from on-chip memory to a single-cycle
// processor one at a time and follows its next-PC response.
module inst_feeder
  import inst_feeder_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int MAX_LAT = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  input  logic                     start,
  input  logic [15:0]              n_inst,
  output logic                     in_valid,
  output logic [31:0]              inst,
  input  logic                     out_valid,
  input  logic [31:0]              inst_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic                     proto_err,
  output logic                     addr_err,
  output logic [15:0]              retired,
  output logic [31:0]              pc
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LAT_W  = $clog2(MAX_LAT + 1);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [1:0]       fault_s;
  logic [15:0]      n_lat_r;
  logic [LAT_W-1:0] lat_cnt_r;
  logic [15:0]      retired_inc_s;
  logic [31:0]      rd_data_s;
  logic             idle_like_s;
  logic             accept_s;

  assign idle_like_s   = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_FAULT);
  assign accept_s      = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start;
  assign retired_inc_s = retired + 16'd1;
  assign inst          = in_valid ? rd_data_s : 32'd0;

  inst_feeder_imem #(.DEPTH(DEPTH), .AW(ADDR_W)) u_imem (
    .clk   (clk),
    .we    (ld_en && idle_like_s),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (pc[ADDR_W+1:2]),
    .rdata (rd_data_s)
  );

  // Next-state and fault-cause decode.
  always_comb begin
    state_nxt_s = state_r;
    fault_s     = FLT_NONE;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = (n_inst == 16'd0) ? ST_DONE : ST_FETCH;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FETCH, ST_ISSUE: begin
        // The previous completion must be a single-cycle pulse.
        if (out_valid) begin
          state_nxt_s = ST_FAULT;
          fault_s     = FLT_PROTO;
        end else begin
          state_nxt_s = (state_r == ST_FETCH) ? ST_ISSUE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (out_valid) begin
          if (!fetch_addr_ok(inst_addr, DEPTH)) begin
            state_nxt_s = ST_FAULT;
            fault_s     = FLT_ADDR;
          end else if (retired_inc_s == n_lat_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else if (lat_cnt_r == LAT_W'(MAX_LAT - 1)) begin
          state_nxt_s = ST_FAULT;
          fault_s     = FLT_TIMEOUT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_FAULT: state_nxt_s = ST_FAULT;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      n_lat_r   <= 16'd0;
      lat_cnt_r <= '0;
      in_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
      addr_err  <= 1'b0;
      retired   <= 16'd0;
      pc        <= 32'd0;
    end else begin
      state_r  <= state_nxt_s;
      in_valid <= (state_nxt_s == ST_ISSUE);
      busy     <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_WAIT);
      done     <= (state_nxt_s == ST_DONE);
      if (fault_s == FLT_TIMEOUT) timeout   <= 1'b1;
      if (fault_s == FLT_PROTO)   proto_err <= 1'b1;
      if (fault_s == FLT_ADDR)    addr_err  <= 1'b1;
      if (accept_s) begin
        pc      <= 32'd0;
        retired <= 16'd0;
        n_lat_r <= n_inst;
      end else if ((state_r == ST_WAIT) && out_valid) begin
        pc      <= inst_addr;
        retired <= retired_inc_s;
      end
      if (state_r == ST_ISSUE) begin
        lat_cnt_r <= '0;
      end else if ((state_r == ST_WAIT) && !out_valid) begin
        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_feeder.sv
// Self-checking bench for inst_feeder: directed vector table, reset-mid-run
// sequence and randomized runs against an event-level reference model.
module tb_inst_feeder;

  localparam int DEPTH   = 512;
  localparam int MAX_LAT = 10;
  localparam int AW      = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = 32'd0;
  logic          start = 1'b0;
  logic [15:0]   n_inst = 16'd0;
  logic          in_valid;
  logic [31:0]   inst;
  logic          out_valid = 1'b0;
  logic [31:0]   inst_addr = 32'd0;
  logic          busy, done, timeout, proto_err, addr_err;
  logic [15:0]   retired;
  logic [31:0]   pc;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] shadow [DEPTH];
  int          lat_a  [64];
  logic [31:0] nxt_a  [64];

  typedef struct {
    logic [15:0] n;
    int          lat;
    logic [31:0] first;
    bit          hold2;
    bit          disturb;
    logic [3:0]  eflags;   // {done, timeout, proto_err, addr_err}
    logic [15:0] eret;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs [9];

  inst_feeder #(.DEPTH(DEPTH), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .n_inst(n_inst), .in_valid(in_valid), .inst(inst),
    .out_valid(out_valid), .inst_addr(inst_addr), .busy(busy), .done(done),
    .timeout(timeout), .proto_err(proto_err), .addr_err(addr_err),
    .retired(retired), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_in_valid"}, 32'(in_valid), 32'd0);
    chk({nm, "_inst"}, inst, 32'd0);
    chk({nm, "_status"}, {27'd0, busy, done, timeout, proto_err, addr_err}, 32'd0);
    chk({nm, "_retired"}, 32'(retired), 32'd0);
    chk({nm, "_pc"}, pc, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; ld_en = 1'b0; out_valid = 1'b0; inst_addr = 32'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_plan(input int lat, input logic [31:0] first);
    logic [31:0] p;
    p = 32'd0;
    for (int j = 0; j < 64; j++) begin
      lat_a[j] = lat;
      nxt_a[j] = (j == 0 && first != 32'hFFFF_FFFF) ? first : p + 32'd4;
      p = nxt_a[j];
    end
  endtask

  // Predicts issue times/words and the final outcome, then drives a run with a
  // reactive responder (latency lat_a[j], next PC nxt_a[j]) and checks each cycle.
  task automatic run_plan(input logic [15:0] n, input bit hold2, input bit disturb, output int oc);
    int          issue_t [64];
    logic [31:0] issue_w [64];
    int          ni, end_cyc, t, r, resp_at, jr;
    logic [31:0] epc, cur_addr, exp_w;
    logic [15:0] eret;
    logic [3:0]  ef;
    bit          exp_v;
    ni = 0; epc = 32'd0; eret = 16'd0; t = 2; oc = 0; end_cyc = 1;
    if (n != 16'd0) begin
      for (int j = 0; j < 64; j++) begin
        issue_t[ni] = t; issue_w[ni] = shadow[epc[10:2]]; ni++;
        if (lat_a[j] < 1 || lat_a[j] > MAX_LAT) begin oc = 1; end_cyc = t + MAX_LAT + 1; break; end
        r = t + lat_a[j];
        epc = nxt_a[j]; eret = eret + 16'd1;
        if (epc[1:0] != 2'b00 || epc >= 32'(4 * DEPTH)) begin oc = 3; end_cyc = r + 1; break; end
        if (eret == n) begin oc = 0; end_cyc = r + 1; break; end
        if (hold2 && j == 0) begin oc = 2; end_cyc = r + 2; break; end
        t = r + 2;
      end
    end
    ef = (oc == 0) ? 4'b1000 : (oc == 1) ? 4'b0100 : (oc == 2) ? 4'b0010 : 4'b0001;
    jr = 0; resp_at = -1000; cur_addr = 32'd0;
    for (int cyc = 0; cyc <= end_cyc + 3; cyc++) begin
      @(negedge clk);
      exp_v = 1'b0; exp_w = 32'd0;
      for (int k = 0; k < ni; k++) begin
        if (issue_t[k] == cyc) begin exp_v = 1'b1; exp_w = issue_w[k]; end
      end
      chk("in_valid", 32'(in_valid), 32'(exp_v));
      chk("inst", inst, exp_w);
      chk("busy", 32'(busy), 32'(n != 16'd0 && cyc >= 1 && cyc < end_cyc));
      if (n != 16'd0 && cyc == end_cyc - 1)
        chk("flags_early", 32'({done, timeout, proto_err, addr_err}), 32'd0);
      if (cyc >= end_cyc)
        chk("flags", 32'({done, timeout, proto_err, addr_err}), 32'(ef));
      if (cyc == end_cyc) begin
        chk("retired", 32'(retired), 32'(eret));
        chk("pc", pc, epc);
      end
      if (in_valid && jr < 64) begin
        resp_at = (lat_a[jr] == 0) ? -1000 : cyc + lat_a[jr];
        cur_addr = nxt_a[jr];
        jr++;
      end
      out_valid = (cyc == resp_at) || (hold2 && jr == 1 && resp_at >= 0 && cyc == resp_at + 1);
      inst_addr = out_valid ? cur_addr : 32'd0;
      start     = (cyc == 0) || (disturb && cyc == 3) || (oc != 0 && cyc == end_cyc);
      n_inst    = (disturb && cyc == 3) ? 16'd1 : n;
      ld_en     = disturb && cyc == 3;
      ld_addr   = '0;
      ld_data   = 32'hDEAD_BEEF;
    end
    start = 1'b0; out_valid = 1'b0; inst_addr = 32'd0; ld_en = 1'b0;
  endtask

  initial begin
    int oc;
    int last_oc;
    logic [31:0] a;
    logic [15:0] rn;
    bit rh;

    vecs[0] = '{16'd3, 2, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'b1000, 16'd3, 32'h0000_000C};
    vecs[1] = '{16'd3, 3, 32'h0000_0010, 1'b0, 1'b0, 4'b1000, 16'd3, 32'h0000_0018};
    vecs[2] = '{16'd2, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0100, 16'd0, 32'h0000_0000};
    vecs[3] = '{16'd3, 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'b0010, 16'd1, 32'h0000_0004};
    vecs[4] = '{16'd3, 2, 32'h0000_0006, 1'b0, 1'b0, 4'b0001, 16'd1, 32'h0000_0006};
    vecs[5] = '{16'd3, 4, 32'h0000_0800, 1'b0, 1'b0, 4'b0001, 16'd1, 32'h0000_0800};
    vecs[6] = '{16'd0, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b1000, 16'd0, 32'h0000_0000};
    vecs[7] = '{16'd2, MAX_LAT, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b1000, 16'd2, 32'h0000_0008};
    vecs[8] = '{16'd2, 1, 32'h0000_07FC, 1'b0, 1'b0, 4'b0001, 16'd2, 32'h0000_0800};

    do_reset();
    chk_reset("reset");

    for (int i = 0; i < DEPTH; i++) begin
      shadow[i] = (i < 3) ? 32'hA0 + 32'(i) : $urandom;
      @(negedge clk);
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = shadow[i];
    end
    @(negedge clk);
    ld_en = 1'b0;

    for (int v = 0; v < 9; v++) begin
      do_reset();
      set_plan(vecs[v].lat, vecs[v].first);
      run_plan(vecs[v].n, vecs[v].hold2, vecs[v].disturb, oc);
      chk($sformatf("vec%0d_flags", v), 32'({done, timeout, proto_err, addr_err}), 32'(vecs[v].eflags));
      chk($sformatf("vec%0d_retired", v), 32'(retired), 32'(vecs[v].eret));
      chk($sformatf("vec%0d_pc", v), pc, vecs[v].epc);
    end

    // Reset while the first instruction is outstanding.
    do_reset();
    @(negedge clk); start = 1'b1; n_inst = 16'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_issue", 32'(in_valid), 32'd1);
    chk("mid_inst", inst, shadow[0]);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("mid_rst");
    set_plan(2, 32'hFFFF_FFFF);
    run_plan(16'd3, 1'b0, 1'b0, oc);
    chk("rerun_retired", 32'(retired), 32'd3);

    // Randomized runs; DONE runs chain straight into the next start.
    last_oc = 0;
    for (int it = 0; it < 30; it++) begin
      if (last_oc != 0) do_reset();
      rn = 16'($urandom_range(0, 5));
      rh = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < 64; j++) begin
        lat_a[j] = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, MAX_LAT));
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        case ($urandom_range(0, 9))
          0:       a = a | 32'd2;
          1:       a = 32'h800 + (32'($urandom_range(0, 4095)) << 2);
          default: a = a;
        endcase
        nxt_a[j] = a;
      end
      run_plan(rn, rh, 1'b0, oc);
      last_oc = oc;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
